// File: rtl/mips_mc_pkg.sv
// Shared constants for the multicycle MIPS control path and datapath.
package mips_mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp from the main FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PCSrc selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM states; encodings 12..15 are unreachable and recover to S_FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decode: ALUOp from the FSM plus funct -> ALUCtl.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl
);

    // Fixed add/sub for address and branch math; funct decides only for R-type
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS core: sequences each instruction,
// drives datapath selects/enables, counts retired instructions, flags illegal opcodes.
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUCtl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic             retire_now;
    logic             illegal_now;

    // Raw Moore decode of the current state, before reset gating
    logic       ctl_iord, ctl_mem_write, ctl_ir_write, ctl_reg_dst, ctl_mem_to_reg;
    logic       ctl_reg_write, ctl_src_a, ctl_pc_write, ctl_branch, ctl_unreachable;
    logic [1:0] ctl_src_b, ctl_pc_src, ctl_alu_op;
    logic [2:0] dec_alu_ctl;

    mips_alu_decoder u_alu_decoder (
        .alu_op  (ctl_alu_op),
        .funct   (funct),
        .alu_ctl (dec_alu_ctl)
    );

    // State register, retired counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire_now) begin
                retired_q <= retired_q + CntOne;
            end
            if (illegal_now) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state logic; retire/illegal strobes mark the edge that leaves a state
    always_comb begin
        state_d     = state_q;
        retire_now  = 1'b0;
        illegal_now = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_now = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d    = S_FETCH;
                retire_now = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore control decode per state
    always_comb begin
        ctl_iord        = 1'b0;
        ctl_mem_write   = 1'b0;
        ctl_ir_write    = 1'b0;
        ctl_reg_dst     = 1'b0;
        ctl_mem_to_reg  = 1'b0;
        ctl_reg_write   = 1'b0;
        ctl_src_a       = 1'b0;
        ctl_src_b       = SRCB_B;
        ctl_pc_src      = PCSRC_ALU;
        ctl_alu_op      = ALUOP_ADD;
        ctl_pc_write    = 1'b0;
        ctl_branch      = 1'b0;
        ctl_unreachable = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctl_src_b    = SRCB_FOUR;
                ctl_ir_write = 1'b1;
                ctl_pc_write = 1'b1;
            end
            S_DECODE: ctl_src_b = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                ctl_src_a = 1'b1;
                ctl_src_b = SRCB_IMM;
            end
            S_MEMRD: ctl_iord = 1'b1;
            S_MEMWB: begin
                ctl_mem_to_reg = 1'b1;
                ctl_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctl_iord      = 1'b1;
                ctl_mem_write = 1'b1;
            end
            S_EXEC: begin
                ctl_src_a  = 1'b1;
                ctl_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctl_reg_dst   = 1'b1;
                ctl_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctl_src_a  = 1'b1;
                ctl_alu_op = ALUOP_SUB;
                ctl_pc_src = PCSRC_ALUOUT;
                ctl_branch = 1'b1;
            end
            S_ADDIWB: ctl_reg_write = 1'b1;
            S_JUMP: begin
                ctl_pc_src   = PCSRC_JUMP;
                ctl_pc_write = 1'b1;
            end
            default: ctl_unreachable = 1'b1;
        endcase
    end

    // Output stage: reset forces enables and selects low and the ALU to add
    always_comb begin
        IorD     = ctl_iord;
        MemWrite = ctl_mem_write;
        IRWrite  = ctl_ir_write;
        RegDst   = ctl_reg_dst;
        MemtoReg = ctl_mem_to_reg;
        RegWrite = ctl_reg_write;
        ALUSrcA  = ctl_src_a;
        ALUSrcB  = ctl_src_b;
        PCSrc    = ctl_pc_src;
        PCEn     = ctl_pc_write | (ctl_branch & zero);
        ALUCtl   = ctl_unreachable ? 3'b000 : dec_alu_ctl;
        if (!reset) begin
            IorD     = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = SRCB_B;
            PCSrc    = PCSRC_ALU;
            PCEn     = 1'b0;
            ALUCtl   = ALU_ADD;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench: a per-instruction model builds the expected cycle trace,
// a negedge compare process checks it; literal checks pin the model.
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUCtl;
    logic [3:0]  state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    mips_mc_control #(.CNT_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUCtl   (ALUCtl),
        .PCSrc    (PCSrc),
        .PCEn     (PCEn),
        .state    (state),
        .retired  (retired),
        .illegal  (illegal)
    );

    typedef struct {
        int         st;
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca, pcen;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluctl;
        int         ret;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_ret = 0;
    logic m_ill = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected ALU code for an R-type funct
    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // A quiet cycle: nothing enabled, ALU adding, current counters
    function automatic exp_t quiet(input int st);
        exp_t e;
        e.st = st; e.iord = 0; e.memwrite = 0; e.irwrite = 0; e.regdst = 0;
        e.memtoreg = 0; e.regwrite = 0; e.srca = 0; e.pcen = 0;
        e.srcb = 2'b00; e.pcsrc = 2'b00; e.aluctl = 3'b010;
        e.ret = m_ret; e.ill = m_ill;
        return e;
    endfunction

    // Build the cycle trace of one instruction; keep only the first 'upto' cycles
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int upto);
        exp_t seq[$];
        exp_t e;
        bit   known = 1'b1;
        e = quiet(0); e.srcb = 2'b01; e.irwrite = 1; e.pcen = 1; seq.push_back(e);
        e = quiet(1); e.srcb = 2'b11; seq.push_back(e);
        case (op)
            6'h23: begin
                e = quiet(2); e.srca = 1; e.srcb = 2'b10; seq.push_back(e);
                e = quiet(3); e.iord = 1; seq.push_back(e);
                e = quiet(4); e.memtoreg = 1; e.regwrite = 1; seq.push_back(e);
            end
            6'h2B: begin
                e = quiet(2); e.srca = 1; e.srcb = 2'b10; seq.push_back(e);
                e = quiet(5); e.iord = 1; e.memwrite = 1; seq.push_back(e);
            end
            6'h00: begin
                e = quiet(6); e.srca = 1; e.aluctl = alu_of(fn); seq.push_back(e);
                e = quiet(7); e.regdst = 1; e.regwrite = 1; seq.push_back(e);
            end
            6'h04: begin
                e = quiet(8); e.srca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
                seq.push_back(e);
            end
            6'h08: begin
                e = quiet(9); e.srca = 1; e.srcb = 2'b10; seq.push_back(e);
                e = quiet(10); e.regwrite = 1; seq.push_back(e);
            end
            6'h02: begin
                e = quiet(11); e.pcsrc = 2'b10; e.pcen = 1; seq.push_back(e);
            end
            default: known = 1'b0;
        endcase
        for (int i = 0; i < seq.size() && i < upto; i++) exp_q.push_back(seq[i]);
        if (upto >= seq.size()) begin
            if (known) m_ret++;
            else m_ill = 1'b1;
        end
    endtask

    // Per-cycle compare against the model trace
    always @(negedge clk) begin : cmp_proc
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",    state,    e.st);
            chk("IorD",     IorD,     e.iord);
            chk("MemWrite", MemWrite, e.memwrite);
            chk("IRWrite",  IRWrite,  e.irwrite);
            chk("RegDst",   RegDst,   e.regdst);
            chk("MemtoReg", MemtoReg, e.memtoreg);
            chk("RegWrite", RegWrite, e.regwrite);
            chk("ALUSrcA",  ALUSrcA,  e.srca);
            chk("ALUSrcB",  ALUSrcB,  e.srcb);
            chk("ALUCtl",   ALUCtl,   e.aluctl);
            chk("PCSrc",    PCSrc,    e.pcsrc);
            chk("PCEn",     PCEn,     e.pcen);
            chk("retired",  retired,  e.ret);
            chk("illegal",  illegal,  e.ill);
        end
    end

    // Drive one instruction from FETCH and wait (bounded) for its trace to drain
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int upto);
        opcode = op; funct = fn; zero = z;
        model_instr(op, fn, z, upto);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk("trace_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        #1;
    endtask

    // Hold reset low for two edges, checking gating and cleared state
    task automatic do_reset();
        reset = 1'b0; zero = 1'b1; opcode = 6'h02;
        @(negedge clk);
        chk("rst_IRWrite",  IRWrite,  0);
        chk("rst_MemWrite", MemWrite, 0);
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_PCEn",     PCEn,     0);
        chk("rst_IorD",     IorD,     0);
        chk("rst_ALUSrcB",  ALUSrcB,  0);
        chk("rst_PCSrc",    PCSrc,    0);
        chk("rst_ALUCtl",   ALUCtl,   3'b010);
        @(posedge clk); #1;
        chk("rst_state_1st", state,   0);
        chk("rst_retired",   retired, 0);
        chk("rst_illegal",   illegal, 0);
        @(posedge clk); #1;
        reset = 1'b1; m_ret = 0; m_ill = 1'b0;
        chk("rst_state", state, 0);
    endtask

    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

    initial begin
        reset = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
        do_reset();

        // R-type with every funct plus an unknown one
        for (int i = 0; i < 6; i++) begin
            run_instr(6'h00, fns[i], 1'b0, 99);
            if (i == 0) chk("lit_retired_after_add", retired, 1);
        end

        do_reset();
        run_instr(6'h23, 6'h00, 1'b0, 99);
        run_instr(6'h2B, 6'h00, 1'b0, 99);
        chk("lit_retired_lw_sw", retired, 2);

        run_instr(6'h04, 6'h00, 1'b1, 99);
        run_instr(6'h04, 6'h00, 1'b0, 99);
        run_instr(6'h08, 6'h00, 1'b1, 99);

        run_instr(6'h3F, 6'h00, 1'b0, 99);
        chk("lit_illegal_set", illegal, 1);
        chk("lit_retired_after_illegal", retired, 5);
        run_instr(6'h02, 6'h00, 1'b0, 99);
        chk("lit_retired_after_j", retired, 6);
        chk("lit_illegal_sticky", illegal, 1);

        // lw aborted in MEMRD by reset, then a clean lw
        run_instr(6'h23, 6'h00, 1'b0, 3);
        chk("lit_in_memrd", state, 3);
        do_reset();
        run_instr(6'h23, 6'h00, 1'b0, 99);
        chk("lit_retired_after_abort", retired, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
